// File: rtl/image_xform_engine_if.sv
// Single-word read/write request bus between the transform engine and the memory controller.
interface image_xform_engine_if #(
  parameter int unsigned ADDR_LEN     = 32,
  parameter int unsigned MEM_DATA_LEN = 64
);
  logic                    rd_valid;
  logic                    rd_ready;
  logic [9:0]              rd_burst_len;
  logic [ADDR_LEN-1:0]     rd_addr;
  logic [MEM_DATA_LEN-1:0] rd_data;
  logic                    rd_burst_finish;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [9:0]              wr_burst_len;
  logic [ADDR_LEN-1:0]     wr_addr;
  logic [MEM_DATA_LEN-1:0] wr_data;
  logic                    wr_burst_finish;

  modport master (
    output rd_valid, rd_burst_len, rd_addr,
    input  rd_ready, rd_data, rd_burst_finish,
    output wr_valid, wr_burst_len, wr_addr, wr_data,
    input  wr_ready, wr_burst_finish
  );

  modport slave (
    input  rd_valid, rd_burst_len, rd_addr,
    output rd_ready, rd_data, rd_burst_finish,
    input  wr_valid, wr_burst_len, wr_addr, wr_data,
    output wr_ready, wr_burst_finish
  );
endinterface

// File: rtl/image_xform_engine.sv
// Per-pixel geometric transform: walks destination pixels in raster order, fetches the
// mapped source word (or substitutes a fill word) and writes it to the ping-pong destination.
module image_xform_engine #(
  parameter int unsigned VIDEO_WIDTH  = 960,
  parameter int unsigned VIDEO_HEIGHT = 540,
  parameter int unsigned MEM_DATA_LEN = 64,
  parameter int unsigned ADDR_LEN     = 32,
  parameter int unsigned RD_BASE_0    = 240000,
  parameter int unsigned RD_BASE_1    = 500000,
  parameter int unsigned WR_BASE_0    = 760000,
  parameter int unsigned WR_BASE_1    = 1020000,
  parameter logic [MEM_DATA_LEN-1:0] FILL_VALUE = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [2:0]  cfg_mode,
  input  logic [11:0] cfg_x_shift,
  input  logic [11:0] cfg_y_shift,
  input  logic [3:0]  cfg_scale,
  output logic        busy,
  output logic        frame_done,
  output logic        buf_sel,
  output logic        error,
  image_xform_engine_if.master mem
);
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_READ, S_WRITE, S_NEXT, S_DONE} state_t;

  localparam logic [2:0] MODE_PASS    = 3'd0;
  localparam logic [2:0] MODE_XSHIFT  = 3'd1;
  localparam logic [2:0] MODE_YSHIFT  = 3'd2;
  localparam logic [2:0] MODE_SCALE   = 3'd3;
  localparam logic [2:0] MODE_HMIRROR = 3'd4;
  localparam logic [2:0] MODE_VMIRROR = 3'd5;

  localparam logic [11:0]         X_LAST = 12'(VIDEO_WIDTH - 1);
  localparam logic [11:0]         Y_LAST = 12'(VIDEO_HEIGHT - 1);
  localparam logic [15:0]         W16    = 16'(VIDEO_WIDTH);
  localparam logic [15:0]         H16    = 16'(VIDEO_HEIGHT);
  localparam logic [ADDR_LEN-1:0] W_A    = ADDR_LEN'(VIDEO_WIDTH);

  state_t                  state_reg;
  logic [11:0]             x_reg, y_reg, xs_reg, ys_reg;
  logic [3:0]              s_reg;
  logic [2:0]              mode_reg;
  logic                    busy_reg, done_reg, buf_sel_reg, error_reg;
  logic                    rd_valid_reg, wr_valid_reg;
  logic [ADDR_LEN-1:0]     rd_addr_reg, wr_addr_reg;
  logic [MEM_DATA_LEN-1:0] wr_data_reg;

  logic [15:0]             x16, y16, sx_next, sy_next;
  logic                    src_ok_next;
  logic [ADDR_LEN-1:0]     src_base, dst_base, rd_addr_next, wr_addr_next;
  logic                    unused_ready;

  assign unused_ready = &{1'b0, mem.rd_ready, mem.wr_ready};

  // Source coordinate from the latched mode; products stay in 16 bits so nothing wraps.
  always_comb begin
    x16         = {4'd0, x_reg};
    y16         = {4'd0, y_reg};
    sx_next     = x16;
    sy_next     = y16;
    src_ok_next = 1'b1;
    case (mode_reg)
      MODE_XSHIFT: begin
        src_ok_next = (x16 >= {4'd0, xs_reg});
        sx_next     = x16 - {4'd0, xs_reg};
      end
      MODE_YSHIFT: begin
        src_ok_next = (y16 >= {4'd0, ys_reg});
        sy_next     = y16 - {4'd0, ys_reg};
      end
      MODE_SCALE: begin
        sx_next     = x16 * {12'd0, s_reg};
        sy_next     = y16 * {12'd0, s_reg};
        src_ok_next = (sx_next < W16) && (sy_next < H16);
      end
      MODE_HMIRROR: sx_next = W16 - 16'd1 - x16;
      MODE_VMIRROR: sy_next = H16 - 16'd1 - y16;
      default: ;
    endcase
    src_base     = buf_sel_reg ? ADDR_LEN'(RD_BASE_1) : ADDR_LEN'(RD_BASE_0);
    dst_base     = buf_sel_reg ? ADDR_LEN'(WR_BASE_1) : ADDR_LEN'(WR_BASE_0);
    rd_addr_next = src_base + ADDR_LEN'(sy_next) * W_A + ADDR_LEN'(sx_next);
    wr_addr_next = dst_base + ADDR_LEN'(y16) * W_A + ADDR_LEN'(x16);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      xs_reg       <= '0;
      ys_reg       <= '0;
      s_reg        <= '0;
      mode_reg     <= MODE_PASS;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      buf_sel_reg  <= 1'b0;
      error_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      wr_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      if (frame_start && state_reg != S_IDLE) error_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (frame_start) begin
            xs_reg <= cfg_x_shift;
            ys_reg <= cfg_y_shift;
            s_reg  <= cfg_scale;
            // Illegal configurations degrade to a plain copy so the frame still completes.
            if (cfg_mode > MODE_VMIRROR || (cfg_mode == MODE_SCALE && cfg_scale == 4'd0)) begin
              mode_reg  <= MODE_PASS;
              error_reg <= 1'b1;
            end else begin
              mode_reg  <= cfg_mode;
            end
            x_reg     <= '0;
            y_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_CALC;
          end
        end
        S_CALC: begin
          rd_addr_reg <= rd_addr_next;
          wr_addr_reg <= wr_addr_next;
          if (src_ok_next) begin
            rd_valid_reg <= 1'b1;
            state_reg    <= S_READ;
          end else begin
            wr_data_reg  <= FILL_VALUE;
            wr_valid_reg <= 1'b1;
            state_reg    <= S_WRITE;
          end
        end
        S_READ: begin
          if (mem.rd_burst_finish) begin
            wr_data_reg  <= mem.rd_data;
            rd_valid_reg <= 1'b0;
            wr_valid_reg <= 1'b1;
            state_reg    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem.wr_burst_finish) begin
            wr_valid_reg <= 1'b0;
            state_reg    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (x_reg == X_LAST) begin
            x_reg <= '0;
            if (y_reg == Y_LAST) begin
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              buf_sel_reg <= ~buf_sel_reg;
              state_reg   <= S_DONE;
            end else begin
              y_reg     <= y_reg + 12'd1;
              state_reg <= S_CALC;
            end
          end else begin
            x_reg     <= x_reg + 12'd1;
            state_reg <= S_CALC;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy             = busy_reg;
  assign frame_done       = done_reg;
  assign buf_sel          = buf_sel_reg;
  assign error            = error_reg;
  assign mem.rd_valid     = rd_valid_reg;
  assign mem.rd_burst_len = 10'd1;
  assign mem.rd_addr      = rd_addr_reg;
  assign mem.wr_valid     = wr_valid_reg;
  assign mem.wr_burst_len = 10'd1;
  assign mem.wr_addr      = wr_addr_reg;
  assign mem.wr_data      = wr_data_reg;
endmodule

// File: tb/tb_image_xform_engine.sv
// Scoreboard bench for image_xform_engine on an 8x4 frame with a word-echo memory model.
module tb_image_xform_engine;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int RB0 = 240000;
  localparam int RB1 = 500000;
  localparam int WB0 = 760000;
  localparam int WB1 = 1020000;
  localparam logic [63:0] FILL = 64'h0000_0000_0000_F1F1;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [2:0]  cfg_mode;
  logic [11:0] cfg_x_shift, cfg_y_shift;
  logic [3:0]  cfg_scale;
  logic        busy, frame_done, buf_sel, error;

  image_xform_engine_if #(.ADDR_LEN(32), .MEM_DATA_LEN(64)) mem_if();

  image_xform_engine #(
    .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H), .MEM_DATA_LEN(64), .ADDR_LEN(32),
    .RD_BASE_0(RB0), .RD_BASE_1(RB1), .WR_BASE_0(WB0), .WR_BASE_1(WB1),
    .FILL_VALUE(FILL)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_mode(cfg_mode),
    .cfg_x_shift(cfg_x_shift), .cfg_y_shift(cfg_y_shift), .cfg_scale(cfg_scale),
    .busy(busy), .frame_done(frame_done), .buf_sel(buf_sel), .error(error),
    .mem(mem_if.master)
  );

  always #5 clk = ~clk;

  assign mem_if.rd_ready = 1'b1;
  assign mem_if.wr_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int rd_cnt, wr_cnt, done_cnt;
  logic [31:0] first_rd;
  bit rand_en = 0;
  bit stray_en = 0;
  bit exp_buf_after;
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wa_q[$];
  logic [63:0] exp_wd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: answers each request after 0 (or random 0..5) extra cycles, data = address.
  initial begin
    int rd_wait, wr_wait, rd_delay, wr_delay;
    rd_wait = 0; wr_wait = 0; rd_delay = 0; wr_delay = 0;
    mem_if.rd_burst_finish = 1'b0;
    mem_if.wr_burst_finish = 1'b0;
    mem_if.rd_data = '0;
    forever begin
      @(negedge clk);
      if (stray_en) begin
        mem_if.rd_burst_finish = 1'b1;
        mem_if.wr_burst_finish = 1'b1;
      end else begin
        if (mem_if.rd_burst_finish) mem_if.rd_burst_finish = 1'b0;
        else if (mem_if.rd_valid) begin
          if (rd_wait >= rd_delay) begin
            mem_if.rd_burst_finish = 1'b1;
            mem_if.rd_data = 64'(mem_if.rd_addr);
            rd_wait = 0;
            rd_delay = rand_en ? int'($urandom_range(0, 5)) : 0;
          end else rd_wait++;
        end else rd_wait = 0;
        if (mem_if.wr_burst_finish) mem_if.wr_burst_finish = 1'b0;
        else if (mem_if.wr_valid) begin
          if (wr_wait >= wr_delay) begin
            mem_if.wr_burst_finish = 1'b1;
            wr_wait = 0;
            wr_delay = rand_en ? int'($urandom_range(0, 5)) : 0;
          end else wr_wait++;
        end else wr_wait = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a new request appears on either port.
  initial begin
    bit rd_seen, wr_seen;
    logic [31:0] ea;
    logic [63:0] ed;
    rd_seen = 0; wr_seen = 0;
    forever begin
      @(negedge clk);
      if (mem_if.rd_valid && mem_if.wr_valid) chk("rd_wr_overlap", 1, 0);
      if (frame_done) begin
        done_cnt++;
        chk("buf_sel_at_done", buf_sel, exp_buf_after);
      end
      if (mem_if.rd_valid && !rd_seen) begin
        rd_seen = 1;
        rd_cnt++;
        if (rd_cnt == 1) first_rd = mem_if.rd_addr;
        $display("rd addr=%0d", mem_if.rd_addr);
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(mem_if.rd_addr), 0);
        else begin
          ea = exp_rd_q.pop_front();
          chk("rd_addr", 64'(mem_if.rd_addr), 64'(ea));
        end
      end else if (!mem_if.rd_valid) rd_seen = 0;
      if (mem_if.wr_valid && !wr_seen) begin
        wr_seen = 1;
        wr_cnt++;
        $display("wr addr=%0d data=%0h", mem_if.wr_addr, mem_if.wr_data);
        if (exp_wa_q.size() == 0) chk("wr_unexpected", 64'(mem_if.wr_addr), 0);
        else begin
          ea = exp_wa_q.pop_front();
          ed = exp_wd_q.pop_front();
          chk("wr_addr", 64'(mem_if.wr_addr), 64'(ea));
          chk("wr_data", mem_if.wr_data, ed);
        end
      end else if (!mem_if.wr_valid) wr_seen = 0;
    end
  end

  task automatic build_exp(input int mode, input int xs, input int ys, input int s, input bit bsel);
    int sx, sy, rb, wb;
    bit ok;
    rb = bsel ? RB1 : RB0;
    wb = bsel ? WB1 : WB0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        ok = 1; sx = x; sy = y;
        case (mode)
          1: if (x < xs) ok = 0; else sx = x - xs;
          2: if (y < ys) ok = 0; else sy = y - ys;
          3: if (s != 0) begin sx = x * s; sy = y * s; ok = (sx < W) && (sy < H); end
          4: sx = W - 1 - x;
          5: sy = H - 1 - y;
          default: ;
        endcase
        exp_wa_q.push_back(32'(wb + y * W + x));
        if (ok) begin
          exp_rd_q.push_back(32'(rb + sy * W + sx));
          exp_wd_q.push_back(64'(rb + sy * W + sx));
        end else exp_wd_q.push_back(FILL);
      end
    end
  endtask

  task automatic start_frame(input int mode, input int xs, input int ys, input int s, input bit bsel);
    build_exp(mode, xs, ys, s, bsel);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    exp_buf_after = ~bsel;
    cfg_mode = 3'(mode); cfg_x_shift = 12'(xs); cfg_y_shift = 12'(ys); cfg_scale = 4'(s);
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic finish_frame(input int exp_rd, input bit disturb);
    bit got;
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (disturb && c == 20) begin cfg_mode = 3'd4; cfg_x_shift = 12'd5; frame_start = 1'b1; end
      if (disturb && c == 21) frame_start = 1'b0;
      if (done_cnt > 0) begin got = 1; break; end
    end
    if (!got) begin
      chk("frame_timeout", 1, 0);
      exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    end else begin
      repeat (3) @(negedge clk);
      #1;
      chk("frame_done_count", done_cnt, 1);
      chk("read_count", rd_cnt, exp_rd);
      chk("write_count", wr_cnt, W * H);
      chk("rd_queue_left", exp_rd_q.size(), 0);
      chk("wr_queue_left", exp_wa_q.size(), 0);
      chk("buf_sel_after", buf_sel, exp_buf_after);
      chk("busy_after", busy, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_valid"}, mem_if.rd_valid, 0);
    chk({tag, "_wr_valid"}, mem_if.wr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_buf_sel"}, buf_sel, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_rd_addr"}, 64'(mem_if.rd_addr), 0);
    chk({tag, "_wr_addr"}, 64'(mem_if.wr_addr), 0);
    chk({tag, "_wr_data"}, mem_if.wr_data, 0);
    chk({tag, "_burst_len"}, {mem_if.rd_burst_len, mem_if.wr_burst_len}, {10'd1, 10'd1});
  endtask

  initial begin
    bit got;
    rst = 1'b0; frame_start = 1'b0;
    cfg_mode = '0; cfg_x_shift = '0; cfg_y_shift = '0; cfg_scale = 4'd1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Stray finish strobes while idle must not start anything.
    stray_en = 1;
    repeat (2) @(negedge clk);
    stray_en = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_busy", busy, 0);
    chk("stray_valids", {mem_if.rd_valid, mem_if.wr_valid}, 0);

    // PASS, buffer 0, with first-request latency
    start_frame(0, 0, 0, 1, 0);
    #1;
    chk("lat_calc_rd_valid", mem_if.rd_valid, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk); #1;
    chk("lat_read_rd_valid", mem_if.rd_valid, 1);
    chk("lat_rd_addr", 64'(mem_if.rd_addr), 64'(RB0));
    finish_frame(32, 0);
    chk("pass_error", error, 0);

    start_frame(1, 3, 0, 1, 1);   // XSHIFT 3, buffer 1
    finish_frame(20, 0);
    start_frame(3, 0, 0, 2, 0);   // SCALE 2, buffer 0
    finish_frame(8, 0);
    start_frame(4, 0, 0, 1, 1);   // HMIRROR, buffer 1
    finish_frame(32, 0);
    chk("hmirror_first_rd", 64'(first_rd), 64'(RB1 + 7));
    start_frame(5, 0, 0, 1, 0);   // VMIRROR, buffer 0
    finish_frame(32, 0);
    chk("vmirror_first_rd", 64'(first_rd), 64'(RB0 + 24));
    chk("legal_frames_error", error, 0);

    // Random latencies, cfg changed and frame_start pulsed mid-frame
    rand_en = 1;
    start_frame(0, 0, 0, 1, 1);
    finish_frame(32, 1);
    rand_en = 0;
    chk("midframe_start_error", error, 1);

    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("reset2");
    @(negedge clk); rst = 1'b1;

    start_frame(3, 0, 0, 0, 0);   // SCALE with s=0 behaves as PASS
    finish_frame(32, 0);
    chk("scale0_error", error, 1);

    // Abort with reset while pixel 10 is being written
    start_frame(0, 0, 0, 1, 1);
    got = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (wr_cnt == 11 && mem_if.wr_valid) begin got = 1; break; end
    end
    chk("abort_reached_pixel10", got, 1);
    #1 rst = 1'b0;
    #1;
    check_reset_vals("abort");
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_frame(0, 0, 0, 1, 0);
    #1;
    @(negedge clk); #1;
    chk("restart_rd_addr", 64'(mem_if.rd_addr), 64'(RB0));
    finish_frame(32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
